snn_ttd_decoder: RTL and testbench

Time-to-data (TTD) decoder at the output end of the SNN core; the counterpart of the data-to-time input encoding. It observes the N_NEURONS output spike lines over a fixed window of 2^TTD_WIDTH cycles and converts each spike train to a TTD_WIDTH-bit value. Decoding uses time-to-first-spike or saturating spike count. It drives the core's output_vector/finish path and raises a one-cycle finish when results are valid.

---
 rtl/snn_ttd_decoder.sv | 117 +++++++++++
 tb/tb_snn_ttd_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snn_ttd_decoder.sv
// Time-to-data decoder: watches N spike lines over a 2^TTD_WIDTH-cycle window and
// turns each spike train into a TTD_WIDTH-bit value (time-to-first-spike or spike count).
module snn_ttd_decoder #(
    parameter int N_NEURONS   = 4,
    parameter int TTD_WIDTH   = 5,
    parameter int DECODE_MODE = 0
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           start,
    input  logic [N_NEURONS-1:0]           spike_in,
    output logic [N_NEURONS*TTD_WIDTH-1:0] data_out,
    output logic [N_NEURONS-1:0]           fired,
    output logic                           busy,
    output logic                           finish,
    output logic [1:0]                     state_dbg
);

    localparam logic [TTD_WIDTH-1:0] MAX = {TTD_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [TTD_WIDTH-1:0]             tick_q, tick_d;
    logic [N_NEURONS*TTD_WIDTH-1:0]   work_q, work_d;
    logic [N_NEURONS-1:0]             wfired_q, wfired_d;
    logic [N_NEURONS*TTD_WIDTH-1:0]   data_q, data_d;
    logic [N_NEURONS-1:0]             fired_q, fired_d;
    logic                             busy_q, busy_d;
    logic                             finish_q, finish_d;

    // Handshake: start is a level sampled on a rising edge only while IDLE; anything
    // else is dropped. finish is high for exactly the DONE cycle, when data_out/fired
    // already carry the new window's result.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        work_d   = work_q;
        wfired_d = wfired_q;
        data_d   = data_q;
        fired_d  = fired_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    tick_d   = '0;
                    work_d   = '0;
                    wfired_d = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (spike_in[i]) begin
                        if (DECODE_MODE == 0) begin
                            if (!wfired_q[i]) begin
                                work_d[i*TTD_WIDTH +: TTD_WIDTH] = MAX - tick_q;
                                wfired_d[i] = 1'b1;
                            end
                        end else begin
                            if (work_q[i*TTD_WIDTH +: TTD_WIDTH] != MAX) begin
                                work_d[i*TTD_WIDTH +: TTD_WIDTH] =
                                    work_q[i*TTD_WIDTH +: TTD_WIDTH] + 1'b1;
                            end
                            wfired_d[i] = 1'b1;
                        end
                    end
                end
                // The last tick's spikes must land in the published result, so the
                // outputs take the freshly updated working values, not the registered ones.
                if (tick_q == MAX) begin
                    state_d = DONE;
                    data_d  = work_d;
                    fired_d = wfired_d;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE);
        finish_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            work_q   <= '0;
            wfired_q <= '0;
            data_q   <= '0;
            fired_q  <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            work_q   <= work_d;
            wfired_q <= wfired_d;
            data_q   <= data_d;
            fired_q  <= fired_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign data_out  = data_q;
    assign fired     = fired_q;
    assign busy      = busy_q;
    assign finish    = finish_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_snn_ttd_decoder.sv
// Bench for snn_ttd_decoder: a TTFS and a rate instance run in lockstep on shared
// stimulus; expected results are queued at start and checked when finish appears.
module tb_snn_ttd_decoder;

    localparam int N   = 4;
    localparam int W   = 5;
    localparam int WIN = 1 << W;
    localparam int MAXV = WIN - 1;
    localparam int RW  = N * W + N;

    logic           CLK;
    logic           nRST;
    logic           start;
    logic [N-1:0]   spike_in;
    logic [N*W-1:0] data_out_a, data_out_b;
    logic [N-1:0]   fired_a, fired_b;
    logic           busy_a, busy_b, finish_a, finish_b;
    logic [1:0]     state_dbg_a, state_dbg_b;

    snn_ttd_decoder #(.N_NEURONS(N), .TTD_WIDTH(W), .DECODE_MODE(0)) dut_ttfs (
        .CLK(CLK), .nRST(nRST), .start(start), .spike_in(spike_in),
        .data_out(data_out_a), .fired(fired_a), .busy(busy_a), .finish(finish_a),
        .state_dbg(state_dbg_a)
    );

    snn_ttd_decoder #(.N_NEURONS(N), .TTD_WIDTH(W), .DECODE_MODE(1)) dut_rate (
        .CLK(CLK), .nRST(nRST), .start(start), .spike_in(spike_in),
        .data_out(data_out_b), .fired(fired_b), .busy(busy_b), .finish(finish_b),
        .state_dbg(state_dbg_b)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_a_q[$];
    logic [RW-1:0] exp_b_q[$];
    int            fin_q[$];
    logic [N-1:0]  pat [WIN];
    bit            stim_done = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // Reference: result packed as {fired, value[N-1] .. value[0]}.
    function automatic logic [RW-1:0] model(input int mode);
        logic [RW-1:0] r;
        int first, cnt, val;
        r = '0;
        for (int i = 0; i < N; i++) begin
            first = -1;
            cnt   = 0;
            for (int t = 0; t < WIN; t++) begin
                if (pat[t][i]) begin
                    if (first < 0) first = t;
                    cnt++;
                end
            end
            if (mode == 0) val = (first < 0) ? 0 : MAXV - first;
            else           val = (cnt > MAXV) ? MAXV : cnt;
            r[i*W +: W] = val[W-1:0];
            r[N*W + i]  = (mode == 0) ? (first >= 0) : (cnt > 0);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pat_clear();
        for (int t = 0; t < WIN; t++) pat[t] = '0;
    endtask

    task automatic pat_random();
        int dens;
        dens = $urandom_range(2, 10);
        for (int t = 0; t < WIN; t++)
            for (int i = 0; i < N; i++)
                pat[t][i] = ($urandom_range(0, 99) < dens);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            start    = 1'b0;
            spike_in = N'($urandom);
        end
    endtask

    task automatic run_window(input bit noise);
        @(posedge CLK); #1;
        start    = 1'b1;
        spike_in = N'($urandom);
        exp_a_q.push_back(model(0));
        exp_b_q.push_back(model(1));
        fin_q.push_back(cyc + WIN + 1);
        for (int t = 0; t < WIN; t++) begin
            @(posedge CLK); #1;
            start    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            spike_in = pat[t];
        end
        @(posedge CLK); #1;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        spike_in = N'($urandom);
    endtask

    task automatic abort_window(input int at_tick);
        @(posedge CLK); #1;
        start = 1'b1;
        spike_in = '0;
        exp_a_q.push_back(model(0));
        exp_b_q.push_back(model(1));
        fin_q.push_back(cyc + WIN + 1);
        for (int t = 0; t <= at_tick; t++) begin
            @(posedge CLK); #1;
            start    = 1'b0;
            spike_in = pat[t];
        end
        #1 nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRST     = 1'b0;
        start    = 1'b1;
        spike_in = '1;
        repeat (3) @(posedge CLK);
        #1;
        nRST     = 1'b1;
        start    = 1'b0;
        spike_in = '0;
        idle(5);

        pat_clear();
        pat[0][0] = 1'b1; pat[10][1] = 1'b1; pat[5][2] = 1'b1; pat[7][2] = 1'b1;
        run_window(1'b0);

        pat_clear();
        for (int t = 0; t < WIN; t++) pat[t][0] = 1'b1;
        pat[1][1] = 1'b1; pat[2][1] = 1'b1; pat[30][1] = 1'b1; pat[31][2] = 1'b1;
        run_window(1'b1);
        idle(3);

        pat_clear();
        pat[0][0] = 1'b1; pat[31][1] = 1'b1; pat[3][3] = 1'b1;
        run_window(1'b0);
        idle(2);

        pat_clear();
        pat[0][0] = 1'b1; pat[4][2] = 1'b1;
        abort_window(12);
        idle(2);

        pat_clear();
        pat[0][0] = 1'b1; pat[10][1] = 1'b1; pat[5][2] = 1'b1; pat[7][2] = 1'b1;
        run_window(1'b0);

        for (int k = 0; k < 8; k++) begin
            pat_random();
            run_window(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(6);
        stim_done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    logic [RW-1:0] held_a = '0;
    logic [RW-1:0] held_b = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [RW-1:0] ea, eb;
        int ef;
        if (!nRST) begin
            exp_a_q.delete();
            exp_b_q.delete();
            fin_q.delete();
            held_a = '0;
            held_b = '0;
            chk("reset_outputs_ttfs", {fired_a, data_out_a, busy_a, finish_a}, '0);
            chk("reset_outputs_rate", {fired_b, data_out_b, busy_b, finish_b}, '0);
        end else if (finish_a || finish_b) begin
            if (fin_q.size() == 0) begin
                chk("finish_unexpected", {finish_a, finish_b}, '0);
            end else begin
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                ef = fin_q.pop_front();
                chk("finish_ttfs", finish_a, 1);
                chk("finish_rate", finish_b, 1);
                chk("finish_cycle", cyc, ef);
                chk("result_ttfs", {fired_a, data_out_a}, ea);
                chk("result_rate", {fired_b, data_out_b}, eb);
                chk("busy_in_done", {busy_a, busy_b}, 2'b11);
                held_a = ea;
                held_b = eb;
            end
        end else if (fin_q.size() == 0) begin
            chk("idle_busy", {busy_a, busy_b}, '0);
        end else if (busy_a || busy_b) begin
            chk("hold_ttfs", {fired_a, data_out_a}, held_a);
            chk("hold_rate", {fired_b, data_out_b}, held_b);
        end

        if (stim_done) begin
            chk("pending_windows", fin_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
